// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//    Shares the single register-bank write port between two writeback
//    requesters. A is the ALU writeback and B is the load / multi-cycle
//    writeback. The arbiter grants one requester per cycle, either
//    round-robin or with A at fixed priority. The winning write goes into a
//    one-entry output stage, and that stage drives the bank.
//
// Ports
//    clk, reset               rising-edge clock, asynchronous active-high reset
//    a_valid/a_ready          requester A handshake
//    a_addr/a_data            requester A destination register and value
//    b_valid/b_ready          requester B handshake
//    b_addr/b_data            requester B destination register and value
//    rf_busy                  bank cannot take a write this cycle
//    rf_write                 write strobe to the bank (output stage valid)
//    rf_write_address/_data   write address and data held in the output stage
//    busy_mask                one-hot of the pending write's register, 0 if none
//    conflict_count           saturating count of cycles where both requesters
//                             contended and a grant was possible
module regfile_write_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int FIXED_PRIORITY = 0,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [ADDR_WIDTH-1:0]    a_addr,
   input  logic [DATA_WIDTH-1:0]    a_data,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [ADDR_WIDTH-1:0]    b_addr,
   input  logic [DATA_WIDTH-1:0]    b_data,
   input  logic                     rf_busy,
   output logic                     rf_write,
   output logic [ADDR_WIDTH-1:0]    rf_write_address,
   output logic [DATA_WIDTH-1:0]    rf_write_data,
   output logic [2**ADDR_WIDTH-1:0] busy_mask,
   output logic [CNT_WIDTH-1:0]     conflict_count
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;

   logic                  out_v_reg,    out_v_next;
   logic [ADDR_WIDTH-1:0] out_addr_reg, out_addr_next;
   logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
   logic                  last_grant_b_reg, last_grant_b_next;  // 1 = B won last
   logic [CNT_WIDTH-1:0]  conflict_count_reg, conflict_count_next;

   logic                  accept;
   logic                  grant_a;
   logic                  grant_b;
   logic                  xfer;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;

   // The stage can take a new entry when it is empty, or when its current
   // entry drains into the bank this cycle. Readies are also held low while
   // reset is asserted.
   assign accept = (~out_v_reg | ~rf_busy) & ~reset;

   // A wins when B is idle, when A has fixed priority, or when B won the
   // last round-robin turn.
   assign grant_a = a_valid & (~b_valid | (FIXED_PRIORITY != 0) | last_grant_b_reg);
   assign grant_b = b_valid & ~grant_a;

   assign a_ready = accept & grant_a;
   assign b_ready = accept & grant_b;

   // A grant already implies that the requester is valid.
   assign xfer     = a_ready | b_ready;
   assign win_addr = a_ready ? a_addr : b_addr;
   assign win_data = a_ready ? a_data : b_data;

   always_comb begin
      out_v_next          = out_v_reg;
      out_addr_next       = out_addr_reg;
      out_data_next       = out_data_reg;
      last_grant_b_next   = last_grant_b_reg;
      conflict_count_next = conflict_count_reg;

      if (xfer) begin
         last_grant_b_next = b_ready;
         if (win_addr != '0) begin
            out_v_next    = 1'b1;
            out_addr_next = win_addr;
            out_data_next = win_data;
         end else begin
            // Writes to register 0 are consumed without loading the stage.
            // Any transfer means the old entry drained, so the stage is empty.
            out_v_next = 1'b0;
         end
      end else if (!rf_busy) begin
         out_v_next = 1'b0;
      end

      if (a_valid && b_valid && accept && !(&conflict_count_reg))
         conflict_count_next = conflict_count_reg + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_v_reg          <= 1'b0;
         out_addr_reg       <= '0;
         out_data_reg       <= '0;
         last_grant_b_reg   <= 1'b1;
         conflict_count_reg <= '0;
      end else begin
         out_v_reg          <= out_v_next;
         out_addr_reg       <= out_addr_next;
         out_data_reg       <= out_data_next;
         last_grant_b_reg   <= last_grant_b_next;
         conflict_count_reg <= conflict_count_next;
      end
   end

   assign rf_write         = out_v_reg;
   assign rf_write_address = out_addr_reg;
   assign rf_write_data    = out_data_reg;
   assign conflict_count   = conflict_count_reg;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         assign busy_mask[gi] = out_v_reg & (out_addr_reg == ADDR_WIDTH'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter. It runs one round-robin
// instance and one fixed-priority instance, and both take the same stimulus.
// Inputs change on the falling edge. Ready signals are sampled 1 time unit
// after inputs change. Registered outputs are sampled on the next falling edge.
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_valid, b_valid, rf_busy;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;

   logic            rr_a_ready, rr_b_ready, rr_write;
   logic [AW-1:0]   rr_addr;
   logic [DW-1:0]   rr_data;
   logic [2**AW-1:0] rr_mask;
   logic [CW-1:0]   rr_cnt;

   logic            fp_a_ready, fp_b_ready, fp_write;
   logic [AW-1:0]   fp_addr;
   logic [DW-1:0]   fp_data;
   logic [2**AW-1:0] fp_mask;
   logic [CW-1:0]   fp_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] bank [2**AW];

   always #5 clk = ~clk;

   regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIORITY(0), .CNT_WIDTH(CW)) dut_rr (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(rr_a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(rr_b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_busy(rf_busy), .rf_write(rr_write), .rf_write_address(rr_addr),
      .rf_write_data(rr_data), .busy_mask(rr_mask), .conflict_count(rr_cnt)
   );

   regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIORITY(1), .CNT_WIDTH(CW)) dut_fp (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(fp_a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(fp_b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_busy(rf_busy), .rf_write(fp_write), .rf_write_address(fp_addr),
      .rf_write_data(fp_data), .busy_mask(fp_mask), .conflict_count(fp_cnt)
   );

   // Bank model: captures each write that the round-robin instance retires.
   always @(posedge clk)
      if (rr_write && !rf_busy) bank[rr_addr] <= rr_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rf_busy = 1'b0;
      a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h1;
      b_valid = 1'b0; b_addr = '0;   b_data = '0;
      #1;
      check("reset_a_ready", rr_a_ready, 0);
      check("reset_rf_write", rr_write, 0);
      check("reset_mask", rr_mask, 0);
      check("reset_cnt", rr_cnt, 0);
      check("reset_wr_addr", rr_addr, 0);
      check("reset_wr_data", rr_data, 0);
      @(negedge clk);
      idle();
      reset = 1'b0;

      // A alone writes r3, with latency 1.
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
      #1;
      check("a_only_ready", rr_a_ready, 1);
      check("a_only_b_ready", rr_b_ready, 0);
      step();
      idle();
      check("a_only_write", rr_write, 1);
      check("a_only_addr", rr_addr, 3);
      check("a_only_data", rr_data, 32'h11);
      check("a_only_mask", rr_mask, 32'h0000_0008);
      step();
      check("a_only_drain", rr_write, 0);
      check("a_only_mask0", rr_mask, 0);

      // Both requesters contend for 4 cycles. After reset, A wins first.
      @(negedge clk); reset_pulse();
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA1;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_a_ready_%0d", i), rr_a_ready, (i % 2 == 0));
         check($sformatf("rr_b_ready_%0d", i), rr_b_ready, (i % 2 == 1));
         check($sformatf("fp_a_ready_%0d", i), fp_a_ready, 1);
         check($sformatf("fp_b_ready_%0d", i), fp_b_ready, 0);
         step();
         check($sformatf("rr_wr_addr_%0d", i), rr_addr, (i % 2 == 0) ? 1 : 2);
         check($sformatf("fp_wr_addr_%0d", i), fp_addr, 1);
      end
      idle();
      check("rr_conflicts", rr_cnt, 4);
      check("fp_conflicts", fp_cnt, 4);
      step();

      // While the stage is full and the bank is busy, the output holds and A stalls.
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h55;
      step();
      a_addr = 5'd6; a_data = 32'h66; rf_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("stall_a_ready_%0d", i), rr_a_ready, 0);
         step();
         check($sformatf("stall_write_%0d", i), rr_write, 1);
         check($sformatf("stall_addr_%0d", i), rr_addr, 5);
         check($sformatf("stall_data_%0d", i), rr_data, 32'h55);
      end
      rf_busy = 1'b0;
      #1;
      check("unstall_a_ready", rr_a_ready, 1);
      step();
      idle();
      check("unstall_addr", rr_addr, 6);
      check("unstall_data", rr_data, 32'h66);
      step();
      check("unstall_drain", rr_write, 0);

      // A write to r0 is consumed and produces no bank write.
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
      #1;
      check("r0_a_ready", rr_a_ready, 1);
      step();
      idle();
      check("r0_no_write", rr_write, 0);
      check("r0_mask", rr_mask, 0);

      // When both requesters target r7, A is written first and B's value is final.
      @(negedge clk); reset_pulse();
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAA;
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBB;
      #1;
      check("same_a_first", rr_a_ready, 1);
      step();
      a_valid = 1'b0;
      check("same_first_data", rr_data, 32'hAA);
      #1;
      check("same_b_ready", rr_b_ready, 1);
      step();
      idle();
      check("same_second_data", rr_data, 32'hBB);
      step();
      check("same_bank_r7", bank[7], 32'hBB);
      check("same_cnt", rr_cnt, 1);

      // An asynchronous reset while the stage is full discards the pending entry.
      a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
      step();
      idle();
      rf_busy = 1'b1;
      check("pre_reset_write", rr_write, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rf_write", rr_write, 0);
      check("async_cnt", rr_cnt, 0);
      check("async_mask", rr_mask, 0);
      @(negedge clk);
      reset = 1'b0; rf_busy = 1'b0;
      a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h10;
      b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h11;
      #1;
      check("post_reset_a_wins", rr_a_ready, 1);
      check("post_reset_b_wait", rr_b_ready, 0);
      step();
      idle();
      check("post_reset_addr", rr_addr, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
